// File: rtl/commit_trace_buffer_if.sv
// Bundle between the dual-issue memory stage, the trace formatter and the commit trace buffer.
// The master side is the pipeline plus consumer; the slave side is the buffer itself.
interface commit_trace_buffer_if #(parameter int CNT_W = 32);
  logic              v1, v2;
  logic [29:0]       pc1, pc2;
  logic [31:0]       inst1, inst2;
  logic [4:0]        rd1, rd2;
  logic [31:0]       data1, data2;
  logic [31:0]       addr1, addr2;
  logic [1:0]        kind1, kind2;
  logic              out_valid;
  logic              out_ready;
  logic [29:0]       out_pc;
  logic [31:0]       out_inst;
  logic [4:0]        out_rd;
  logic [31:0]       out_data;
  logic [31:0]       out_addr;
  logic [1:0]        out_kind;
  logic              stall;
  logic              overflow;
  logic [CNT_W-1:0]  retire_cnt;

  modport master (
    output v1, pc1, inst1, rd1, data1, addr1, kind1,
    output v2, pc2, inst2, rd2, data2, addr2, kind2,
    output out_ready,
    input  out_valid, out_pc, out_inst, out_rd, out_data, out_addr, out_kind,
    input  stall, overflow, retire_cnt
  );

  modport slave (
    input  v1, pc1, inst1, rd1, data1, addr1, kind1,
    input  v2, pc2, inst2, rd2, data2, addr2, kind2,
    input  out_ready,
    output out_valid, out_pc, out_inst, out_rd, out_data, out_addr, out_kind,
    output stall, overflow, retire_cnt
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// In-order FIFO capturing up to two retired records per cycle and draining one per cycle.
// A dual retire is all-or-nothing: if both slots cannot fit, the whole cycle is dropped.
module commit_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input logic             CLK,
  input logic             RST,
  commit_trace_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] addr;
    logic [1:0]  kind;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, wptr_p1;
  logic [PW:0]      cnt_q, cnt_d, free;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;

  rec_t       rec1, rec2, wr0, head;
  logic [1:0] req, acc_n;
  logic       accept, pop, we0, we1;

  // A register write to x0 has no architectural destination.
  function automatic rec_t norm(input logic [29:0] pc, input logic [31:0] inst,
                                input logic [4:0] rd, input logic [31:0] data,
                                input logic [31:0] addr, input logic [1:0] kind);
    rec_t r;
    r.pc   = pc;
    r.inst = inst;
    r.rd   = rd;
    r.data = data;
    r.addr = addr;
    r.kind = (kind == 2'b01 && rd == 5'd0) ? 2'b00 : kind;
    return r;
  endfunction

  assign rec1 = norm(bus.pc1, bus.inst1, bus.rd1, bus.data1, bus.addr1, bus.kind1);
  assign rec2 = norm(bus.pc2, bus.inst2, bus.rd2, bus.data2, bus.addr2, bus.kind2);

  assign req     = {1'b0, bus.v1} + {1'b0, bus.v2};
  assign free    = (PW+1)'(DEPTH) - cnt_q;
  assign accept  = ({{(PW-1){1'b0}}, req} <= free);
  assign acc_n   = accept ? req : 2'd0;
  assign pop     = (cnt_q != '0) && bus.out_ready;
  assign wptr_p1 = wptr_q + PW'(1);

  // The oldest valid slot always lands at the write pointer.
  assign wr0 = bus.v1 ? rec1 : rec2;
  assign we0 = accept && (req != 2'd0);
  assign we1 = accept && (req == 2'd2);

  always_comb begin
    wptr_d = wptr_q + PW'(acc_n);
    rptr_d = rptr_q + (pop ? PW'(1) : PW'(0));
    cnt_d  = cnt_q + (PW+1)'(acc_n) - (PW+1)'(pop);
    ovf_d  = ovf_q | ~accept;
    rcnt_d = rcnt_q + CNT_W'(acc_n);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      rcnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      rcnt_q <= rcnt_d;
    end
  end

  // Storage is not reset; stale entries are masked by the head gating below.
  always_ff @(posedge CLK) begin
    if (we0) mem_q[wptr_q]  <= wr0;
    if (we1) mem_q[wptr_p1] <= rec2;
  end

  assign head = (cnt_q != '0) ? mem_q[rptr_q] : '0;

  assign bus.out_valid  = (cnt_q != '0);
  assign bus.out_pc     = head.pc;
  assign bus.out_inst   = head.inst;
  assign bus.out_rd     = head.rd;
  assign bus.out_data   = head.data;
  assign bus.out_addr   = head.addr;
  assign bus.out_kind   = head.kind;
  assign bus.stall      = (free < (PW+1)'(2));
  assign bus.overflow   = ovf_q;
  assign bus.retire_cnt = rcnt_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (DEPTH=8): ordering, drop, wrap, normalisation, reset.
module tb_commit_trace_buffer;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   failures = 0;

  commit_trace_buffer_if #(.CNT_W(32)) bus ();
  commit_trace_buffer #(.DEPTH(8), .CNT_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.v1 = 0; bus.pc1 = '0; bus.inst1 = '0; bus.rd1 = '0; bus.data1 = '0; bus.addr1 = '0; bus.kind1 = '0;
    bus.v2 = 0; bus.pc2 = '0; bus.inst2 = '0; bus.rd2 = '0; bus.data2 = '0; bus.addr2 = '0; bus.kind2 = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    clr();
  endtask

  task automatic s1(input logic [29:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                    input logic [31:0] data, input logic [31:0] addr, input logic [1:0] kind);
    bus.v1 = 1; bus.pc1 = pc; bus.inst1 = inst; bus.rd1 = rd; bus.data1 = data; bus.addr1 = addr; bus.kind1 = kind;
  endtask

  task automatic s2(input logic [29:0] pc, input logic [31:0] inst, input logic [4:0] rd,
                    input logic [31:0] data, input logic [31:0] addr, input logic [1:0] kind);
    bus.v2 = 1; bus.pc2 = pc; bus.inst2 = inst; bus.rd2 = rd; bus.data2 = data; bus.addr2 = addr; bus.kind2 = kind;
  endtask

  task automatic do_reset();
    RST = 1; tick(); RST = 0;
  endtask

  initial begin
    clr();
    bus.out_ready = 0;
    RST = 0;
    #2;
    do_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_rcnt", bus.retire_cnt, 0);

    // single push, one-cycle latency, then popped
    bus.out_ready = 1;
    s1(30'h10, 32'h00500093, 5'd1, 32'h5, 32'h0, 2'b01);
    tick();
    chk("single_valid", bus.out_valid, 1);
    chk("single_pc", bus.out_pc, 30'h10);
    chk("single_inst", bus.out_inst, 32'h00500093);
    chk("single_rd", bus.out_rd, 1);
    chk("single_kind", bus.out_kind, 2'b01);
    tick();
    chk("single_empty", bus.out_valid, 0);
    chk("single_pc0", bus.out_pc, 0);
    chk("single_rcnt", bus.retire_cnt, 1);

    // fill with dual pushes, consumer stalled
    do_reset();
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      s1(30'h100 + 30'(2*i), 32'h13, 5'd2, 32'(i), 32'h0, 2'b01);
      s2(30'h101 + 30'(2*i), 32'h13, 5'd3, 32'(i), 32'h0, 2'b01);
      tick();
      chk("fill_stall", bus.stall, (i == 3) ? 1 : 0);
      chk("fill_head_hold", bus.out_pc, 30'h100);
    end
    s1(30'h200, 32'h13, 5'd4, 32'h0, 32'h0, 2'b01);
    s2(30'h201, 32'h13, 5'd5, 32'h0, 32'h0, 2'b01);
    tick();
    chk("full_ovf", bus.overflow, 1);
    chk("full_rcnt", bus.retire_cnt, 8);
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", bus.out_valid, 1);
      chk("drain_pc", bus.out_pc, 30'h100 + 30'(i));
      tick();
    end
    chk("drain_empty", bus.out_valid, 0);
    chk("drain_ovf_sticky", bus.overflow, 1);

    // normalisation of rd=0 register write; store fields preserved
    do_reset();
    chk("rst2_ovf", bus.overflow, 0);
    bus.out_ready = 0;
    s1(30'h20, 32'h00000013, 5'd0, 32'h1, 32'h0, 2'b01);
    s2(30'h21, 32'h00f5a023, 5'd3, 32'hdeadbeef, 32'h0000f95c, 2'b11);
    tick();
    chk("norm_pc", bus.out_pc, 30'h20);
    chk("norm_kind0", bus.out_kind, 2'b00);
    bus.out_ready = 1;
    tick();
    chk("store_kind", bus.out_kind, 2'b11);
    chk("store_addr", bus.out_addr, 32'h0000f95c);
    chk("store_data", bus.out_data, 32'hdeadbeef);
    chk("store_rd", bus.out_rd, 3);
    tick();
    chk("norm_empty", bus.out_valid, 0);

    // slot-2 only
    bus.out_ready = 0;
    s2(30'h30, 32'h13, 5'd7, 32'h0, 32'h0, 2'b01);
    tick();
    chk("v2only_pc", bus.out_pc, 30'h30);
    chk("v2only_rcnt", bus.retire_cnt, 3);
    bus.out_ready = 1;
    tick();
    chk("v2only_one_entry", bus.out_valid, 0);

    // wrap and drop-with-pop
    do_reset();
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      s1(30'h40 + 30'(2*i), 32'h13, 5'd1, 32'h0, 32'h0, 2'b01);
      s2(30'h41 + 30'(2*i), 32'h13, 5'd1, 32'h0, 32'h0, 2'b01);
      tick();
    end
    s1(30'h46, 32'h13, 5'd1, 32'h0, 32'h0, 2'b01);
    tick();
    chk("seven_stall", bus.stall, 1);
    chk("seven_rcnt", bus.retire_cnt, 7);
    bus.out_ready = 1;
    s1(30'h50, 32'h13, 5'd1, 32'h0, 32'h0, 2'b01);
    s2(30'h51, 32'h13, 5'd1, 32'h0, 32'h0, 2'b01);
    tick();
    chk("droppop_ovf", bus.overflow, 1);
    chk("droppop_rcnt", bus.retire_cnt, 7);
    chk("droppop_head", bus.out_pc, 30'h41);
    chk("droppop_stall", bus.stall, 0);
    for (int i = 1; i < 7; i++) begin
      chk("wrap_drain_pc", bus.out_pc, 30'h40 + 30'(i));
      tick();
    end
    chk("wrap_empty", bus.out_valid, 0);
    bus.out_ready = 0;
    s1(30'h60, 32'h13, 5'd1, 32'h0, 32'h0, 2'b01);
    s2(30'h61, 32'h13, 5'd1, 32'h0, 32'h0, 2'b10);
    tick();
    chk("wrap_head0", bus.out_pc, 30'h60);
    chk("wrap_rcnt", bus.retire_cnt, 9);
    bus.out_ready = 1;
    tick();
    chk("wrap_head1", bus.out_pc, 30'h61);
    chk("wrap_kind1", bus.out_kind, 2'b10);
    tick();
    chk("wrap_done", bus.out_valid, 0);

    // reset mid-stream with entries queued
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      s1(30'h70 + 30'(i), 32'hffff, 5'd9, 32'hffffffff, 32'hffffffff, 2'b11);
      if (i < 2) s2(30'h78 + 30'(i), 32'hffff, 5'd9, 32'hffffffff, 32'hffffffff, 2'b11);
      tick();
    end
    chk("pre_rst_valid", bus.out_valid, 1);
    do_reset();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ovf", bus.overflow, 0);
    chk("mid_rst_rcnt", bus.retire_cnt, 0);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_fields", {bus.out_pc, bus.out_kind, bus.out_rd}, 0);
    chk("mid_rst_data", {bus.out_data, bus.out_addr}, 0);
    chk("mid_rst_inst", bus.out_inst, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the dual-issue memory stage (slots M1/M2) and captures up to two retired-instruction records per cycle.
- Stores records in an in-order FIFO and drains them one per cycle over a valid/ready port to the trace/UART formatter.
- Raises a stall request toward the pipeline when it cannot absorb a worst-case dual retire.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 4
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
v1  in  1  slot-1 (older) record valid
pc1  in  30  slot-1 word PC (byte PC = {pc1,2'b00})
inst1  in  32  slot-1 instruction word
rd1  in  5  slot-1 destination register
data1  in  32  slot-1 write/store data
addr1  in  32  slot-1 memory address (load/store)
kind1  in  2  slot-1 kind: 00 none, 01 reg write, 10 load, 11 store
v2, pc2, inst2, rd2, data2, addr2, kind2  in  same widths  slot-2 (younger) record
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head
out_pc  out  30  head PC
out_inst  out  32  head instruction
out_rd  out  5  head rd
out_data  out  32  head data
out_addr  out  32  head address
out_kind  out  2  head kind
stall  out  1  free entries < 2
overflow  out  1  sticky: a push was dropped
retire_cnt  out  CNT_W  records accepted since reset

Behaviour:
- Reset (RST=1 at edge): write/read pointers 0, count 0, overflow 0, retire_cnt 0. Outputs: out_valid 0, all out_* fields 0, stall 0. Reset mid-stream discards all entries.
- Record normalisation on push: kind 01 with rd 0 stored as kind 00 (no destination). Loads/stores keep rd as given.
- Push count req = v1 + v2 (0..2). Order: slot-1 first, then slot-2; v2 alone pushes slot-2 as a single entry; v1 alone pushes slot-1.
- Acceptance: accept iff req <= free, where free = DEPTH - count at the start of the cycle. A pop in the same cycle does not create space for that cycle's push.
- Insufficient space: the whole request (both slots) is dropped, overflow set to 1 and held until reset, retire_cnt unchanged.
- Pop: out_valid & out_ready advances the read pointer by 1.
- Simultaneous push and pop: both take effect; count_next = count + accepted - popped.
- Pointers wrap modulo DEPTH. A two-entry push may straddle the wrap (slot-1 at DEPTH-1, slot-2 at 0).
- Head outputs: read combinationally from registered storage at the read pointer. out_valid = (count != 0). All out_* fields forced to 0 when out_valid = 0.
- Latency: a record pushed at edge N is visible on out_* after edge N when the FIFO was empty (one cycle from input to output).
- out_* must hold stable while out_valid=1 and out_ready=0.
- stall = (DEPTH - count) < 2, combinational from registered count only (no input dependence, no loop with pipeline stall).
- retire_cnt += accepted records each cycle, wraps modulo 2^CNT_W.
- Ordering invariant: output sequence equals program order (slot-1 before slot-2, older cycles before newer).

Test Plan:
- Reset then single push v1=1 pc1=30'h10, inst1=32'h00500093, rd1=1, kind1=01, out_ready=1 -> next cycle: out_valid=1, out_pc=30'h10, out_kind=01; following cycle out_valid=0; retire_cnt=1.
- Dual push each cycle for 4 cycles with out_ready=0, DEPTH=8 -> count reaches 8, stall=1 once count>=7; 5th dual push dropped, overflow=1, retire_cnt=8; draining gives pcs in exact slot-1/slot-2 program order.
- kind1=01 rd1=0 and kind2=11 addr2=32'h0000f95c data2=32'hdeadbeef -> popped records show kind 00, then kind 11 with addr 32'h0000f95c, data 32'hdeadbeef.
- v1=0 v2=1 -> exactly one entry; count increments by 1; retire_cnt +1.
- Wrap: pre-fill then drain to read pointer=7, write pointer=7; dual push -> entries land at 7 and 0, popped in order; simultaneous pop with count=7 and dual push -> dropped (free=1 < 2), overflow=1, and the pop still completes.
- Assert RST with 5 entries queued and out_ready=0 -> next cycle out_valid=0, overflow=0, retire_cnt=0, stall=0; out_* all 0.
